exception_sequencer: RTL and testbench

- Multicycle exception-entry sequencer for the MIPS datapath.
- Samples the three exception sources and picks one by priority.
- Writes EPC and Cause (codes 253/254/255), reads the handler-address byte from memory at the cause-code address, and loads it into PC.
- Sits between the control unit's exception detection and the PC/EPC/Cause registers and memory read port; stalls the control unit while active.

---
 rtl/exception_sequencer.sv | 172 +++++++++++++++++
 tb/tb_exception_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/exception_sequencer.sv
// ============================================================================
// Module      : exception_sequencer
// Description : Multicycle MIPS exception entry. Latches cause/EPC, fetches the
//               handler byte from memory and loads it into PC. The optional
//               macro EXC_DOUBLE_FAULT_EN enables sticky double-fault detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exception_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned EPC_OFFSET     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic        mem_rd_valid,
    input  logic [7:0]  mem_rd_data,
    output logic        mem_rd_req,
    output logic [31:0] mem_addr,
    output logic        cause_wr,
    output logic [31:0] cause_out,
    output logic        epc_wr,
    output logic [31:0] epc_out,
    output logic        pc_wr,
    output logic [31:0] pc_out,
    output logic        busy,
    output logic        timeout_err,
    output logic        double_fault
);

    localparam logic [31:0] c_epc_offset = EPC_OFFSET[31:0];
    localparam logic [7:0]  c_timeout    = TIMEOUT_CYCLES[7:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAUSE = 2'd1,
        FETCH = 2'd2,
        JUMP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_code;
    logic [31:0] r_epc;
    logic [7:0]  r_byte;
    logic [7:0]  r_cnt;
    logic        r_timeout;
    logic        w_any_exc;
    logic        w_timeout_hit;
    logic [31:0] w_code;

    assign w_any_exc     = exc_opcode | exc_overflow | exc_div0;
    // The counter is loaded with 1 on FETCH entry, so FETCH lasts exactly
    // TIMEOUT_CYCLES cycles when valid never arrives.
    assign w_timeout_hit = (r_cnt == c_timeout);

    always_comb begin
        w_code = 32'd255;
        if (exc_opcode) begin
            w_code = 32'd253;
        end else if (exc_overflow) begin
            w_code = 32'd254;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        mem_rd_req   = 1'b0;
        cause_wr     = 1'b0;
        epc_wr       = 1'b0;
        pc_wr        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_exc) begin
                    w_next_state = CAUSE;
                end
            end
            CAUSE: begin
                busy         = 1'b1;
                cause_wr     = 1'b1;
                epc_wr       = 1'b1;
                w_next_state = FETCH;
            end
            FETCH: begin
                busy       = 1'b1;
                mem_rd_req = 1'b1;
                if (mem_rd_valid || w_timeout_hit) begin
                    w_next_state = JUMP;
                end
            end
            JUMP: begin
                busy         = 1'b1;
                pc_wr        = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_code    <= 32'd0;
            r_epc     <= 32'd0;
            r_byte    <= 8'd0;
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_exc) begin
                        r_code <= w_code;
                        r_epc  <= pc_in - c_epc_offset;
                    end
                end
                CAUSE: begin
                    r_cnt <= 8'd1;
                end
                FETCH: begin
                    // Valid beats a coincident timeout.
                    if (mem_rd_valid) begin
                        r_byte <= mem_rd_data;
                    end else if (w_timeout_hit) begin
                        r_byte    <= 8'h00;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef EXC_DOUBLE_FAULT_EN
    logic r_double_fault;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_double_fault <= 1'b0;
        end else if (busy && w_any_exc) begin
            r_double_fault <= 1'b1;
        end
    end

    assign double_fault = r_double_fault;
`else
    assign double_fault = 1'b0;
`endif

    assign mem_addr    = r_code;
    assign cause_out   = r_code;
    assign epc_out     = r_epc;
    assign pc_out      = {24'b0, r_byte};
    assign timeout_err = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_exception_sequencer.sv
// ============================================================================
// Module      : tb_exception_sequencer
// Description : Directed self-checking bench for exception_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exception_sequencer;

`ifdef EXC_DOUBLE_FAULT_EN
    localparam logic [31:0] c_df_exp = 32'd1;
`else
    localparam logic [31:0] c_df_exp = 32'd0;
`endif

    logic        clk;
    logic        reset_n;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_div0;
    logic [31:0] pc_in;
    logic        mem_rd_valid;
    logic [7:0]  mem_rd_data;
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic        cause_wr;
    logic [31:0] cause_out;
    logic        epc_wr;
    logic [31:0] epc_out;
    logic        pc_wr;
    logic [31:0] pc_out;
    logic        busy;
    logic        timeout_err;
    logic        double_fault;

    int errors = 0;
    int checks = 0;

    exception_sequencer #(
        .TIMEOUT_CYCLES(16),
        .EPC_OFFSET    (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .exc_opcode  (exc_opcode),
        .exc_overflow(exc_overflow),
        .exc_div0    (exc_div0),
        .pc_in       (pc_in),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data (mem_rd_data),
        .mem_rd_req  (mem_rd_req),
        .mem_addr    (mem_addr),
        .cause_wr    (cause_wr),
        .cause_out   (cause_out),
        .epc_wr      (epc_wr),
        .epc_out     (epc_out),
        .pc_wr       (pc_wr),
        .pc_out      (pc_out),
        .busy        (busy),
        .timeout_err (timeout_err),
        .double_fault(double_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs all single-bit outputs: {busy,req,cause_wr,epc_wr,pc_wr,tmo,df}
    function automatic logic [31:0] flags();
        return {25'd0, busy, mem_rd_req, cause_wr, epc_wr, pc_wr, timeout_err, double_fault};
    endfunction

    initial begin
        reset_n      = 1'b0;
        exc_opcode   = 1'b0;
        exc_overflow = 1'b0;
        exc_div0     = 1'b0;
        pc_in        = 32'd0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = 8'd0;
        step();
        step();
        chk("reset_flags", flags(), 32'd0);
        chk("reset_cause", cause_out, 32'd0);
        chk("reset_epc", epc_out, 32'd0);
        chk("reset_pc", pc_out, 32'd0);
        chk("reset_addr", mem_addr, 32'd0);
        reset_n = 1'b1;
        step();
        chk("idle_after_release", flags(), 32'd0);

        // Single overflow, valid on the first FETCH cycle
        exc_overflow = 1'b1;
        pc_in        = 32'h40;
        step();
        chk("ovf_cause_flags", flags(), 32'b1011000);
        chk("ovf_cause_code", cause_out, 32'd254);
        chk("ovf_epc", epc_out, 32'h3C);
        exc_overflow = 1'b0;
        step();
        chk("ovf_fetch_flags", flags(), 32'b1100000);
        chk("ovf_addr", mem_addr, 32'd254);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 8'h80;
        step();
        chk("ovf_jump_flags", flags(), 32'b1000100);
        chk("ovf_pc", pc_out, 32'h80);
        mem_rd_valid = 1'b0;
        step();
        chk("ovf_back_idle", flags(), 32'd0);
        chk("ovf_cause_hold", cause_out, 32'd254);

        // All three sources at once: opcode wins
        exc_opcode   = 1'b1;
        exc_overflow = 1'b1;
        exc_div0     = 1'b1;
        pc_in        = 32'h100;
        step();
        chk("pri_cause", cause_out, 32'd253);
        chk("pri_epc", epc_out, 32'hFC);
        exc_opcode   = 1'b0;
        exc_overflow = 1'b0;
        exc_div0     = 1'b0;
        step();
        chk("pri_addr", mem_addr, 32'd253);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 8'h11;
        step();
        chk("pri_pc", pc_out, 32'h11);
        chk("pri_pc_wr", {31'd0, pc_wr}, 32'd1);
        mem_rd_valid = 1'b0;
        step();

        // Divide-by-zero timing out after 16 FETCH cycles
        exc_div0 = 1'b1;
        pc_in    = 32'h2000;
        step();
        chk("tmo_cause", cause_out, 32'd255);
        exc_div0 = 1'b0;
        step();
        for (int i = 0; i < 15; i++) step();
        chk("tmo_fetch16_flags", flags(), 32'b1100000);
        step();
        chk("tmo_jump_flags", flags(), 32'b1000110);
        chk("tmo_pc", pc_out, 32'd0);
        step();
        chk("tmo_idle_sticky", flags(), 32'b0000010);

        // pc_in=0 wraps EPC; valid after 5 wait cycles -> pc_wr 8 cycles after E0
        exc_div0 = 1'b1;
        pc_in    = 32'd0;
        step();
        chk("wrap_epc", epc_out, 32'hFFFFFFFC);
        chk("wrap_cause", cause_out, 32'd255);
        exc_div0 = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        chk("wrap_fetch6_flags", flags(), 32'b1100010);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 8'h5A;
        step();
        chk("wrap_jump_flags", flags(), 32'b1000110);
        chk("wrap_pc", pc_out, 32'h5A);
        mem_rd_valid = 1'b0;
        step();

        // Exception pulsed during FETCH of an overflow sequence
        exc_overflow = 1'b1;
        pc_in        = 32'h200;
        step();
        exc_overflow = 1'b0;
        step();
        exc_opcode = 1'b1;
        step();
        chk("df_flag", {31'd0, double_fault}, c_df_exp);
        chk("df_cause_kept", cause_out, 32'd254);
        chk("df_still_fetch", {31'd0, mem_rd_req}, 32'd1);
        exc_opcode   = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 8'h33;
        step();
        chk("df_pc", pc_out, 32'h33);
        chk("df_pc_wr", {31'd0, pc_wr}, 32'd1);
        mem_rd_valid = 1'b0;
        step();

        // Back-to-back: exception held high through JUMP re-enters after one IDLE
        exc_opcode = 1'b1;
        step();
        step();
        mem_rd_valid = 1'b1;
        mem_rd_data  = 8'h44;
        step();
        chk("b2b_jump", {31'd0, pc_wr}, 32'd1);
        mem_rd_valid = 1'b0;
        step();
        chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
        step();
        chk("b2b_reentry_cause_wr", {31'd0, cause_wr}, 32'd1);
        exc_opcode = 1'b0;
        step();
        chk("b2b_in_fetch", {31'd0, mem_rd_req}, 32'd1);

        // Asynchronous reset mid-FETCH
        reset_n = 1'b0;
        #1;
        chk("arst_flags", flags(), 32'd0);
        chk("arst_cause", cause_out, 32'd0);
        chk("arst_epc", epc_out, 32'd0);
        chk("arst_pc", pc_out, 32'd0);
        step();
        chk("arst_no_pc_wr", {31'd0, pc_wr}, 32'd0);
        reset_n = 1'b1;
        step();
        chk("arst_release_idle", flags(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
